// File: rtl/bootloader_pkg.sv
// Shared CPU definitions: bootloader FSM encoding, bus/address defaults and
// the instruction opcodes a loaded program is built from.
package bootloader_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LOAD_BYTES = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_SET_ADDR  = 3'd2,
        ST_WRITE_RAM = 3'd3,
        ST_FINISH    = 3'd4
    } boot_state_e;

    // Instruction byte = {opcode, operand}
    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_LOAD_IM = 4'h1;
    localparam logic [3:0] OP_ADD     = 4'h2;
    localparam logic [3:0] OP_OUT     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    function automatic logic [7:0] make_instr(input logic [3:0] op, input logic [3:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/bootloader.sv
// Streams a program from the host link into RAM via the control unit's
// BOOT_OUT|MAR_READ and BOOT_OUT|RAM_READ steps while holding the CPU in reset.
module bootloader
    import bootloader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bootload_address,
    output logic              bootload_ram,
    output logic [DATA_W-1:0] boot_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] load_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Negedge so state lines up with the control step counter.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        in_ready         = 1'b0;
        bootload_address = 1'b0;
        bootload_ram     = 1'b0;
        boot_data        = '0;
        done             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_WAIT_BYTE;
                    addr_d  = '0;
                end
            end
            ST_WAIT_BYTE: begin
                in_ready = 1'b1;
                if (in_valid && !abort) begin
                    data_d  = in_data;
                    state_d = ST_SET_ADDR;
                end
            end
            ST_SET_ADDR: begin
                bootload_address = 1'b1;
                boot_data        = DATA_W'(addr_q);
                state_d          = ST_WRITE_RAM;
            end
            ST_WRITE_RAM: begin
                bootload_ram = 1'b1;
                boot_data    = data_q;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_WAIT_BYTE;
                end
            end
            ST_FINISH: begin
                done    = !abort;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase

        // Abort wins over any handshake or step; RAM contents are left alone.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            addr_d  = '0;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign cpu_rst   = busy;
    assign load_addr = addr_q;

endmodule

// File: tb/tb_bootloader.sv
// Directed bench for bootloader: scoreboarded bus steps, RAM/CPU model on top.
module tb_bootloader;
    import bootloader_pkg::*;

    localparam int unsigned AW = ADDR_W_DEF;
    localparam int unsigned DW = DATA_W_DEF;

    typedef struct packed {
        logic       is_addr;
        logic       is_ram;
        logic [7:0] data;
    } bus_ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          bootload_address;
    logic          bootload_ram;
    logic [DW-1:0] boot_data;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic [AW-1:0] load_addr;

    bus_ev_t       exp_q[$];
    logic [7:0]    ram_m[16];
    logic [AW-1:0] mar_m;
    logic [7:0]    prog[16];
    logic [AW-1:0] exp_addr;
    int            done_cnt;
    int            errors;
    int            checks;

    bootloader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .bootload_address (bootload_address),
        .bootload_ram     (bootload_ram),
        .boot_data        (boot_data),
        .cpu_rst          (cpu_rst),
        .busy             (busy),
        .done             (done),
        .load_addr        (load_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sample at posedge (mid-cycle), scoreboard bus steps, model MAR/RAM.
    task automatic observe();
        bus_ev_t e;
        if (bootload_address || bootload_ram) begin
            check("pulse_excl", 32'(bootload_address & bootload_ram), 0);
            check("queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'b0, bootload_address, bootload_ram}, {30'b0, e.is_addr, e.is_ram});
                check("pulse_data", 32'(boot_data), 32'(e.data));
            end
            if (bootload_address) mar_m = boot_data[AW-1:0];
            if (bootload_ram) ram_m[mar_m] = boot_data;
        end else begin
            check("idle_bus", 32'(boot_data), 0);
        end
        if (done) done_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        observe();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {18'b0, in_ready, bootload_address, bootload_ram, cpu_rst, busy, done, boot_data}, 0);
        check({tag, "_addr"}, 32'(load_addr), 0);
    endtask

    task automatic feed(input logic [7:0] b, input int gap, input bit pulse_start);
        bus_ev_t e;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'hAA;
            tick();
            check("gap_in_ready", 32'(in_ready), 1);
            check("gap_addr", 32'(load_addr), 32'(exp_addr));
        end
        check("wait_in_ready", 32'(in_ready), 1);
        check("wait_addr", 32'(load_addr), 32'(exp_addr));
        in_data  = b;
        in_valid = 1'b1;
        start    = pulse_start;
        e = '{is_addr: 1'b1, is_ram: 1'b0, data: 8'(exp_addr)};
        exp_q.push_back(e);
        e = '{is_addr: 1'b0, is_ram: 1'b1, data: b};
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        check("set_addr_req", 32'(bootload_address), 1);
        check("set_in_ready", 32'(in_ready), 0);
        check("set_bus", 32'(boot_data), 32'(exp_addr));
        tick();
        check("wr_ram_req", 32'(bootload_ram), 1);
        check("wr_bus", 32'(boot_data), 32'(b));
        tick();
        if (exp_addr == '1) begin
            check("finish_done", 32'(done), 1);
        end else begin
            check("next_done", 32'(done), 0);
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    task automatic begin_load();
        exp_addr = '0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = prog[0];
        tick();
        start = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_cpu_rst", 32'(cpu_rst), 1);
    endtask

    task automatic run_load(input int gap_idx, input int gap_len, input int start_idx);
        begin_load();
        for (int i = 0; i < 16; i++)
            feed(prog[i], (i == gap_idx) ? gap_len : 0, i == start_idx);
        tick();
        check("post_busy", 32'(busy), 0);
        check("post_cpu_rst", 32'(cpu_rst), 0);
        check("post_done", 32'(done), 0);
        check("post_addr", 32'(load_addr), 0);
    endtask

    initial begin
        logic [3:0] pc;
        logic [3:0] acc;
        logic [3:0] outv;
        bit         halted;

        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        mar_m    = '0;
        for (int i = 0; i < 16; i++) ram_m[i] = 8'h00;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        #2;
        check_all_zero("reset_outputs");
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_all_zero("idle_outputs");

        // Full 16-byte load with in_valid held: done lands on cycle 49.
        for (int i = 0; i < 16; i++) prog[i] = 8'h10 + 8'(i);
        run_load(-1, 0, -1);
        for (int i = 0; i < 16; i++) check("ram_full", 32'(ram_m[i]), 32'(8'h10 + 8'(i)));
        check("done_cnt_1", 32'(done_cnt), 1);

        // Throttled host before the third byte; start pulsed mid-load.
        for (int i = 0; i < 16; i++) prog[i] = 8'h40 + 8'(i);
        run_load(2, 5, 5);
        check("done_cnt_2", 32'(done_cnt), 2);
        check("ram_throttled", 32'(ram_m[2]), 32'h42);

        // start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_ready", 32'(in_ready), 0);

        // Abort after 7 bytes, with a byte offered in the same cycle.
        for (int i = 0; i < 16; i++) prog[i] = 8'h60 + 8'(i);
        begin_load();
        for (int i = 0; i < 7; i++) feed(prog[i], 0, 1'b0);
        check("pre_abort_addr", 32'(load_addr), 7);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_all_zero("abort_outputs");
        tick();
        tick();
        check("abort_no_done", 32'(done_cnt), 2);
        check("abort_ram_kept6", 32'(ram_m[6]), 32'h66);
        check("abort_ram_kept7", 32'(ram_m[7]), 32'h47);

        // Reload from address 0 with a real program, then run it on a CPU model.
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = make_instr(OP_LOAD_IM, 4'd5);
        prog[1] = make_instr(OP_OUT, 4'd0);
        prog[2] = make_instr(OP_HALT, 4'd0);
        run_load(-1, 0, -1);
        check("done_cnt_3", 32'(done_cnt), 3);
        pc     = '0;
        acc    = '0;
        outv   = 4'hF;
        halted = 1'b0;
        for (int s = 0; s < 16 && !halted; s++) begin
            case (ram_m[pc][7:4])
                OP_LOAD_IM: acc = ram_m[pc][3:0];
                OP_ADD:     acc = acc + ram_m[pc][3:0];
                OP_OUT:     outv = acc;
                OP_HALT:    halted = 1'b1;
                default:    ;
            endcase
            if (!halted) pc = pc + 1'b1;
        end
        check("cpu_out", 32'(outv), 5);
        check("cpu_halt", 32'(halted), 1);
        check("cpu_halt_pc", 32'(pc), 2);

        // Async reset while in WRITE_RAM: outputs clear before the next edge.
        for (int i = 0; i < 16; i++) prog[i] = 8'h70 + 8'(i);
        begin_load();
        feed(prog[0], 0, 1'b0);
        feed(prog[1], 0, 1'b0);
        in_data  = 8'h73;
        in_valid = 1'b1;
        exp_q.push_back('{is_addr: 1'b1, is_ram: 1'b0, data: 8'h02});
        tick();
        tick();
        check("pre_rst_wr", 32'(bootload_ram), 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst_outputs");
        tick();
        tick();
        check_all_zero("rst_held_outputs");
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("post_rst_busy", 32'(busy), 0);
        check("rst_no_write", 32'(ram_m[2]), 32'(make_instr(OP_HALT, 4'd0)));
        check("rst_done_cnt", 32'(done_cnt), 3);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
